// File: rtl/data_memory_if.sv
// data_memory_if: CPU data-port bundle between the CPU (master) and data_memory (slave).
//   dataAddress   byte address of the access
//   writeMemData  right-aligned store data
//   memRead       load request
//   memWrite      store request
//   memMode       000 w, 001 h, 010 hu, 011 b, 100 bu, others treated as word
//   readMemData   extended load data (combinational)
//   ready         clear engine finished, accesses honoured
//   fault         sticky illegal-access flag
//   faultAddr     address of the first captured illegal access
//   faultClear    clears fault/faultAddr on the next edge
interface data_memory_if;
    logic [31:0] dataAddress;
    logic [31:0] writeMemData;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  memMode;
    logic [31:0] readMemData;
    logic        ready;
    logic        fault;
    logic [31:0] faultAddr;
    logic        faultClear;

    modport master (
        output dataAddress, writeMemData, memRead, memWrite, memMode, faultClear,
        input  readMemData, ready, fault, faultAddr
    );

    modport slave (
        input  dataAddress, writeMemData, memRead, memWrite, memMode, faultClear,
        output readMemData, ready, fault, faultAddr
    );
endinterface

// File: rtl/data_memory.sv
// data_memory: word-organised data memory on the CPU data port.
//   clk     single clock, rising edge
//   resetN  asynchronous active-low reset
//   bus     data_memory_if slave port (address, store data, read/write strobes, mode,
//           load data, ready, sticky fault record and its clear)
// After reset a sequential engine zeroes one word per cycle; accesses are honoured only once
// ready is high. Loads are combinational; stores use per-byte enables.
module data_memory #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000
) (
    input logic          clk,
    input logic          resetN,
    data_memory_if.slave bus
);
    localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SpanBytes = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [0:0] {StClear, StReady} state_t;

    state_t          stateQ, stateD;
    logic [IdxW-1:0] clearIdxQ, clearIdxD;
    logic            faultQ;
    logic [31:0]     faultAddrQ;
    logic [31:0]     mem [DEPTH_WORDS];

    // Address decode
    logic [31:0]     offset;
    logic [IdxW-1:0] wordIdx;
    logic            inRange, isHalf, isByte, isSigned, misaligned;
    logic            ready, legal, illegal;

    assign ready    = (stateQ == StReady);
    assign offset   = bus.dataAddress - BASE_ADDR;
    assign wordIdx  = offset[IdxW+1:2];
    assign inRange  = ({1'b0, offset} < SpanBytes);
    assign isHalf   = (bus.memMode == 3'b001) || (bus.memMode == 3'b010);
    assign isByte   = (bus.memMode == 3'b011) || (bus.memMode == 3'b100);
    assign isSigned = (bus.memMode == 3'b001) || (bus.memMode == 3'b011);

    always_comb begin
        misaligned = 1'b0;
        if (isHalf) begin
            misaligned = bus.dataAddress[0];
        end else if (!isByte) begin
            misaligned = (bus.dataAddress[1:0] != 2'b00);
        end
    end

    assign legal   = ready && inRange && !misaligned;
    assign illegal = (bus.memRead || bus.memWrite) && ready && !(inRange && !misaligned);

    // Clear engine FSM
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stateQ    <= StClear;
            clearIdxQ <= '0;
        end else begin
            stateQ    <= stateD;
            clearIdxQ <= clearIdxD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        clearIdxD = clearIdxQ;
        unique case (stateQ)
            StClear: begin
                clearIdxD = clearIdxQ + 1'b1;
                if (clearIdxQ == IdxW'(DEPTH_WORDS - 1)) begin
                    stateD = StReady;
                end
            end
            StReady: ;
            default: stateD = StClear;
        endcase
    end

    // Store lane steering
    logic [3:0]  byteEn;
    logic [31:0] wrData;

    always_comb begin
        byteEn = 4'b1111;
        wrData = bus.writeMemData;
        if (isHalf) begin
            byteEn = bus.dataAddress[1] ? 4'b1100 : 4'b0011;
            wrData = {2{bus.writeMemData[15:0]}};
        end else if (isByte) begin
            byteEn = 4'b0001 << bus.dataAddress[1:0];
            wrData = {4{bus.writeMemData[7:0]}};
        end
    end

    // Array has no reset; resetN only gates writes so an edge under reset stores nothing.
    always_ff @(posedge clk) begin
        if (resetN) begin
            if (stateQ == StClear) begin
                mem[clearIdxQ] <= '0;
            end else if (bus.memWrite && legal) begin
                for (int k = 0; k < 4; k++) begin
                    if (byteEn[k]) begin
                        mem[wordIdx][8*k +: 8] <= wrData[8*k +: 8];
                    end
                end
            end
        end
    end

    // Combinational load path
    logic [31:0] wordData, shifted, loadData;
    logic [15:0] halfData;

    assign wordData = mem[wordIdx];
    assign shifted  = wordData >> {bus.dataAddress[1:0], 3'b000};
    assign halfData = bus.dataAddress[1] ? wordData[31:16] : wordData[15:0];

    always_comb begin
        loadData = wordData;
        if (isHalf) begin
            loadData = {{16{isSigned & halfData[15]}}, halfData};
        end else if (isByte) begin
            loadData = {{24{isSigned & shifted[7]}}, shifted[7:0]};
        end
    end

    assign bus.readMemData = (bus.memRead && legal) ? loadData : 32'h0;

    // Sticky fault record; a new capture beats a simultaneous clear.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            faultQ     <= 1'b0;
            faultAddrQ <= '0;
        end else if (illegal && (!faultQ || bus.faultClear)) begin
            faultQ     <= 1'b1;
            faultAddrQ <= bus.dataAddress;
        end else if (bus.faultClear) begin
            faultQ     <= 1'b0;
            faultAddrQ <= '0;
        end
    end

    assign bus.ready     = ready;
    assign bus.fault     = faultQ;
    assign bus.faultAddr = faultAddrQ;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed plus randomized bench for data_memory with a byte-array model.
module tb_data_memory;
    localparam int unsigned Depth = 16;
    localparam int unsigned Bytes = Depth * 4;
    localparam logic [31:0] Base  = 32'h1001_0000;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    data_memory_if bus ();

    data_memory #(
        .DEPTH_WORDS(Depth),
        .BASE_ADDR  (Base)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    int checkCount = 0;
    int failCount  = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model: byte-addressed array plus fault/ready bookkeeping
    logic [7:0]  refMem [Bytes];
    bit          refReady;
    int          refClearLeft;
    bit          refFault;
    logic [31:0] refFaultAddr;

    function automatic bit modeHalf(input logic [2:0] m);
        return (m == 3'd1) || (m == 3'd2);
    endfunction

    function automatic bit modeByte(input logic [2:0] m);
        return (m == 3'd3) || (m == 3'd4);
    endfunction

    function automatic bit addrOk(input logic [31:0] a, input logic [2:0] m);
        logic [31:0] off = a - Base;
        bit aligned;
        if (modeHalf(m)) aligned = (a % 2 == 0);
        else if (modeByte(m)) aligned = 1;
        else aligned = (a % 4 == 0);
        return (off < Bytes) && aligned;
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a, input logic [2:0] m,
                                              input bit rd);
        logic [31:0] off = a - Base;
        logic [15:0] h;
        logic [7:0]  b;
        if (!rd || !refReady || !addrOk(a, m)) return 32'h0;
        if (modeHalf(m)) begin
            h = {refMem[off + 1], refMem[off]};
            return (m == 3'd1) ? {{16{h[15]}}, h} : {16'h0, h};
        end
        if (modeByte(m)) begin
            b = refMem[off];
            return (m == 3'd3) ? {{24{b[7]}}, b} : {24'h0, b};
        end
        return {refMem[off + 3], refMem[off + 2], refMem[off + 1], refMem[off]};
    endfunction

    // Advance one rising edge and apply the model's view of it.
    task automatic stepEdge();
        logic [31:0] a = bus.dataAddress;
        logic [2:0]  m = bus.memMode;
        logic [31:0] d = bus.writeMemData;
        logic [31:0] off = a - Base;
        bit acc = bus.memRead || bus.memWrite;
        bit bad = acc && refReady && !addrOk(a, m);
        bit wasReady = refReady;
        @(posedge clk);
        if (!resetN) begin
            refReady = 0; refClearLeft = Depth; refFault = 0; refFaultAddr = 0;
        end else begin
            if (!wasReady) begin
                refClearLeft--;
                if (refClearLeft == 0) begin
                    refReady = 1;
                    foreach (refMem[i]) refMem[i] = 8'h00;
                end
            end else if (bus.memWrite && addrOk(a, m)) begin
                if (modeByte(m)) begin
                    refMem[off] = d[7:0];
                end else if (modeHalf(m)) begin
                    refMem[off] = d[7:0]; refMem[off + 1] = d[15:8];
                end else begin
                    for (int k = 0; k < 4; k++) refMem[off + k] = d[8*k +: 8];
                end
            end
            if (bad && (!refFault || bus.faultClear)) begin
                refFault = 1; refFaultAddr = a;
            end else if (bus.faultClear) begin
                refFault = 0; refFaultAddr = 0;
            end
        end
        #1;
    endtask

    task automatic setIdle();
        bus.dataAddress = Base; bus.writeMemData = 0; bus.memRead = 0;
        bus.memWrite = 0; bus.memMode = 0; bus.faultClear = 0;
    endtask

    // One bus cycle: drive, check combinational/registered outputs before the edge, step.
    task automatic cycle(input logic [31:0] a, input logic [31:0] d, input bit rd,
                         input bit wr, input logic [2:0] m, input bit fc,
                         output logic [31:0] rdata);
        bus.dataAddress = a; bus.writeMemData = d; bus.memRead = rd;
        bus.memWrite = wr; bus.memMode = m; bus.faultClear = fc;
        @(negedge clk);
        rdata = bus.readMemData;
        checkVal("rdata", rdata, modelRead(a, m, rd));
        checkVal("ready", {31'h0, bus.ready}, {31'h0, refReady});
        checkVal("fault", {31'h0, bus.fault}, {31'h0, refFault});
        checkVal("faultAddr", bus.faultAddr, refFaultAddr);
        stepEdge();
        setIdle();
    endtask

    task automatic applyReset();
        setIdle();
        bus.memRead = 1;
        resetN = 0;
        refReady = 0; refClearLeft = Depth; refFault = 0; refFaultAddr = 0;
        @(posedge clk); #1;
        checkVal("rst_ready", {31'h0, bus.ready}, 32'h0);
        checkVal("rst_fault", {31'h0, bus.fault}, 32'h0);
        checkVal("rst_faultAddr", bus.faultAddr, 32'h0);
        checkVal("rst_rdata", bus.readMemData, 32'h0);
        setIdle();
        resetN = 1;
    endtask

    logic [31:0] r;

    initial begin
        setIdle();
        foreach (refMem[i]) refMem[i] = 8'h00;
        applyReset();

        // ready after exactly Depth edges
        for (int i = 1; i <= Depth; i++) begin
            stepEdge();
            checkVal("ready_cnt", {31'h0, bus.ready}, (i == Depth) ? 32'h1 : 32'h0);
        end
        for (int w = 0; w < Depth; w++) begin
            cycle(Base + 32'(4 * w), 0, 1, 0, 3'd0, 0, r);
            checkVal("zero_word", r, 32'h0);
        end

        // Restart mid-clear
        applyReset();
        for (int i = 1; i <= 7; i++) stepEdge();
        applyReset();
        for (int i = 1; i <= Depth; i++) begin
            stepEdge();
            checkVal("ready_recnt", {31'h0, bus.ready}, (i == Depth) ? 32'h1 : 32'h0);
        end

        // Word store then extended loads
        cycle(Base + 4, 32'h8081_82F3, 0, 1, 3'd0, 0, r);
        cycle(Base + 4, 0, 1, 0, 3'd0, 0, r); checkVal("lw+4", r, 32'h8081_82F3);
        cycle(Base + 4, 0, 1, 0, 3'd3, 0, r); checkVal("lb+4", r, 32'hFFFF_FFF3);
        cycle(Base + 5, 0, 1, 0, 3'd4, 0, r); checkVal("lbu+5", r, 32'h0000_0082);
        cycle(Base + 6, 0, 1, 0, 3'd1, 0, r); checkVal("lh+6", r, 32'hFFFF_8081);
        cycle(Base + 6, 0, 1, 0, 3'd2, 0, r); checkVal("lhu+6", r, 32'h0000_8081);

        // Sub-word merges
        cycle(Base + 8, 32'h5566_7788, 0, 1, 3'd0, 0, r);
        cycle(Base + 9, 32'h0000_00AA, 0, 1, 3'd3, 0, r);
        cycle(Base + 10, 32'h0000_1234, 0, 1, 3'd1, 0, r);
        cycle(Base + 8, 0, 1, 0, 3'd0, 0, r); checkVal("merge+8", r, 32'h1234_AA88);

        // Faults
        cycle(Base + 3, 32'h0000_BEEF, 0, 1, 3'd1, 0, r);
        checkVal("mis_fault", {31'h0, bus.fault}, 32'h1);
        checkVal("mis_faultAddr", bus.faultAddr, Base + 3);
        cycle(Base + 2, 0, 1, 0, 3'd0, 0, r); checkVal("mis_rdata0", r, 32'h0);
        checkVal("sticky_addr", bus.faultAddr, Base + 3);
        cycle(Base + 0, 0, 1, 0, 3'd0, 0, r); checkVal("mis_unchanged", r, 32'h0);
        cycle(Base - 4, 0, 1, 0, 3'd0, 1, r); checkVal("oor_rdata0", r, 32'h0);
        checkVal("clr_win_fault", {31'h0, bus.fault}, 32'h1);
        checkVal("clr_win_addr", bus.faultAddr, Base - 4);
        cycle(Base, 0, 0, 0, 3'd0, 1, r);
        checkVal("clr_fault", {31'h0, bus.fault}, 32'h0);

        // Read and write together
        cycle(Base + 12, 32'hDEAD_BEEF, 1, 1, 3'd0, 0, r); checkVal("rw_pre", r, 32'h0);
        cycle(Base + 12, 0, 1, 0, 3'd0, 0, r); checkVal("rw_post", r, 32'hDEAD_BEEF);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? Base - 32'($urandom_range(1, 8))
                                            : Base + 32'($urandom_range(0, Bytes + 7));
            cycle(a, $urandom, 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0), r);
        end

        // Store during clear is dropped
        applyReset();
        cycle(Base + 20, 32'h1111_1111, 0, 1, 3'd0, 0, r);
        checkVal("clear_nofault", {31'h0, bus.fault}, 32'h0);
        begin
            int budget = 40;
            while (!bus.ready && budget > 0) begin
                stepEdge();
                budget--;
            end
            checkVal("ready_timeout", {31'h0, bus.ready}, 32'h1);
        end
        cycle(Base + 20, 0, 1, 0, 3'd0, 0, r); checkVal("clear_store_lost", r, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data memory that sits on the CPU's data port and answers its load/store requests. It performs byte/halfword/word stores through per-byte write enables and returns sign- or zero-extended load data combinationally, so single-cycle timing is preserved. It also zero-initialises its array after reset with a sequential clear engine and keeps a sticky fault record for misaligned or out-of-range accesses.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; power of two, at least 2.
- `BASE_ADDR`, default 32'h1001_0000: byte address of word 0; must be aligned to `DEPTH_WORDS*4`.
- `clk` input, 1 bit: the single clock; all state changes on the rising edge.
- `resetN` input, 1 bit: asynchronous, active-low reset.
- `dataAddress` input, 32 bits: byte address of the access.
- `writeMemData` input, 32 bits: store data, right-aligned (byte in [7:0], half in [15:0]).
- `memRead` input, 1 bit: load request this cycle.
- `memWrite` input, 1 bit: store request this cycle.
- `memMode` input, 3 bits: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101–111 are treated as word.
- `readMemData` output, 32 bits: extended load data.
- `ready` output, 1 bit: the clear engine is finished and accesses are honoured.
- `fault` output, 1 bit: sticky flag for an illegal access.
- `faultAddr` output, 32 bits: `dataAddress` of the first illegal access captured.
- `faultClear` input, 1 bit: clears `fault` and `faultAddr` on the next edge.

## Operation
- Byte order is little-endian. The byte at offset k of a word sits in bits [8k+7:8k].
- In range means `dataAddress - BASE_ADDR < DEPTH_WORDS*4` (unsigned). Word index is `(dataAddress - BASE_ADDR) >> 2`.
- Misaligned means a half access with address[0]=1, or a word access with address[1:0]≠0. Byte accesses are never misaligned.
- An access is illegal when `(memRead|memWrite)`, `ready`=1, and the address is out of range or misaligned.
- FSM states:
  - CLEAR: writes 0 to word `clearIdx` each cycle and increments `clearIdx`. After writing index `DEPTH_WORDS-1` it moves to READY.
  - READY: normal service. It has no exit except reset.
- Stores (READY, `memWrite`=1, legal):
  - Word: write all four bytes.
  - Half: write the 2 bytes at offset address[1], data from [15:0].
  - Byte: write 1 byte at offset address[1:0], data from [7:0].
  - Bytes not selected are unchanged.
- An illegal store writes nothing. A store in CLEAR is ignored and raises no fault.
- Loads: `readMemData` is combinational from the current array contents.
  - The selected byte or half is sign- or zero-extended per `memMode`.
  - Output is 0 when `memRead`=0, when `ready`=0, or when the access is illegal.
- Fault capture: on the edge of an illegal access with `fault`=0, set `fault`=1 and `faultAddr`=`dataAddress`. Later illegal accesses do not overwrite it.
- `faultClear`=1 clears both fault registers at the edge. If an illegal access occurs in the same cycle, the new capture wins: `fault`=1 with the new address.
- `memRead` and `memWrite` both 1: the store commits at the edge. `readMemData` shows the pre-edge contents during that cycle.

## Timing
- Reset (asynchronous assert, synchronous release): state=CLEAR, `clearIdx`=0, `ready`=0, `fault`=0, `faultAddr`=0, `readMemData`=0. Array contents are not touched asynchronously.
- `ready` rises exactly `DEPTH_WORDS` rising edges after the first edge with `resetN`=1. It is registered, not decoded from `clearIdx`.
- Reset asserted mid-clear or mid-operation restarts the clear from index 0. A store in flight at that edge is lost.
- Store latency is 1 edge. A load of the same address in the next cycle returns the new data.
- Load latency is 0 cycles; the path is combinational from the address to `readMemData`.
- `fault`/`faultAddr` update at the edge that ends the illegal cycle.
- `faultClear` behaves the same in CLEAR and READY.

## Test plan
- Reset with `DEPTH_WORDS`=16, release, count edges → `ready`=1 after exactly 16 edges. Every word then reads 0. Pulse `resetN` low at edge 7 → the count restarts and `ready` rises 16 edges after the new release.
- Word store 32'h8081_82F3 at `BASE_ADDR`+4, then load modes at +4, +5, +6:
  - lw +4 → 32'h8081_82F3
  - lb +4 → 32'hFFFF_FFF3
  - lbu +5 → 32'h0000_0082
  - lh +6 → 32'hFFFF_8081
  - lhu +6 → 32'h0000_8081
- Store byte 8'hAA at +9, then half 16'h1234 at +10, onto word +8 preset to 32'h5566_7788 → lw +8 = 32'h1234_AA88.
- Half store at +3 → word unchanged, `fault`=1, `faultAddr`=`BASE_ADDR`+3. Then lw at +2 in the following cycle → `faultAddr` is still `BASE_ADDR`+3. Then `faultClear` together with an lw at `BASE_ADDR`-4 → `fault`=1, `faultAddr`=`BASE_ADDR`-4.
- `memRead`=`memWrite`=1, word 32'hDEAD_BEEF to a location holding 0 → `readMemData`=0 that cycle and 32'hDEAD_BEEF in the next cycle.
- Store issued while `ready`=0 → no write and no fault; the location reads 0 after `ready`=1.
